vga_timing_dual: RTL
====================

Name: vga_timing_dual

Overview:
- Parametrised successor to the single-mode VGA sync generator: produces hsync/vsync/display_on and pixel coordinates for two runtime-selectable timing sets (A and B).
- Adds a generic integer pixel-clock divider, per-set sync polarity, and a programmable sync/blank delay line to match downstream mixer pipelines.
- Adds line_start/frame_start strobes and a frame counter.
- Sits between the clock/reset domain and the pixel mixer; feeds the board VGA pins.

Parameters:
- HPOS_WIDTH, 11, hpos width; must hold max(A_H_TOTAL, B_H_TOTAL)-1.
- VPOS_WIDTH, 10, vpos width; must hold max(A_V_TOTAL, B_V_TOTAL)-1.
- CLK_DIV, 2, clk cycles per pixel (>=1).
- SYNC_DELAY, 0, pixel ticks by which hsync/vsync/display_on lag hpos/vpos (0..7).
- FRAME_CNT_WIDTH, 8, frame_cnt width.
- A_H_DISPLAY/A_H_FRONT/A_H_SYNC/A_H_BACK, 640/16/96/48, set A horizontal timing.
- A_V_DISPLAY/A_V_BOTTOM/A_V_SYNC/A_V_TOP, 480/10/2/33, set A vertical timing.
- A_HSYNC_POL/A_VSYNC_POL, 0/0, active level of set A syncs.
- B_H_*, 800/40/128/88, and B_V_*, 600/1/4/23, set B timing.
- B_HSYNC_POL/B_VSYNC_POL, 1/1, active level of set B syncs.
- H_TOTAL = DISPLAY+FRONT+SYNC+BACK per set; V_TOTAL likewise.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mode_sel  in  1  requested timing set (0=A, 1=B), sampled only at frame wrap
- pixel_en  out  1  one-cycle strobe; hpos/vpos advance at the end of this cycle
- hpos  out  HPOS_WIDTH  current pixel column
- vpos  out  VPOS_WIDTH  current line
- hsync  out  1  horizontal sync, polarity per active set
- vsync  out  1  vertical sync, polarity per active set
- display_on  out  1  visible-area flag
- line_start  out  1  one-cycle pulse when hpos becomes 0
- frame_start  out  1  one-cycle pulse when (hpos,vpos) becomes (0,0)
- frame_cnt  out  FRAME_CNT_WIDTH  completed-frame count, wraps
- active_mode  out  1  timing set currently in use

Behaviour:
- Reset (async assert, sync release): hpos=0, vpos=0, display_on=0, pixel_en=0, line_start=0, frame_start=0, frame_cnt=0, active_mode=0. hsync=~A_HSYNC_POL and vsync=~A_VSYNC_POL (inactive). Divider count=0. Delay line filled with inactive/blank values.
- Divider: count 0..CLK_DIV-1 on every clk; pixel_en=1 in the cycle where count==CLK_DIV-1. First pulse is cycle CLK_DIV-1 after reset release (cycle 0 = first edge after release). CLK_DIV=1 means pixel_en is constantly 1 after reset.
- Counters, updated at the edge ending a pixel_en cycle:
  - If hpos==H_TOTAL-1: hpos<=0; vpos<=(vpos==V_TOTAL-1)?0:vpos+1.
  - Otherwise hpos<=hpos+1.
  - H_TOTAL and V_TOTAL are taken from active_mode.
- Decode, from the new (next) position at the same edge:
  - display_on = h<H_DISPLAY && v<V_DISPLAY.
  - hsync active when H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC.
  - vsync active when V_DISPLAY+V_BOTTOM <= v < V_DISPLAY+V_BOTTOM+V_SYNC.
  - Output level is the set's POL when active, ~POL otherwise.
- SYNC_DELAY=0: decoded values are registered alongside hpos/vpos and describe the same pixel. SYNC_DELAY=k: they pass a k-deep shift register clocked on pixel_en, so they describe the position k pixel ticks earlier. hpos/vpos are never delayed.
- Strobes: line_start=1 for exactly the one clk cycle after an edge that loads hpos=0. frame_start=1 likewise for the edge that loads (0,0). Both are 0 otherwise, including between pixel_en strobes when CLK_DIV>1.
- frame_cnt increments on the same edge as frame_start; it wraps from 2^FRAME_CNT_WIDTH-1 to 0.
- Mode switch:
  - mode_sel is sampled only at the edge that wraps to (0,0); active_mode is loaded at that edge.
  - The new set's totals, decode thresholds and polarities apply from pixel (0,0) onward.
  - mode_sel toggles mid-frame have no effect, even if toggled back before wrap.
  - Delay-line contents already in flight keep their old-set levels.
- Reset mid-frame: all state returns to reset values immediately (async); the next frame restarts in set A regardless of mode_sel.

Test Plan:
- Small timings: A = H 8/2/2/2, V 4/1/1/1, CLK_DIV=1, SYNC_DELAY=0, pols 0. Release reset and run -> hpos cycles 0..13, vpos 0..6. hsync=0 exactly at hpos 10..11. vsync=0 at vpos 5. display_on=1 iff hpos<8 && vpos<4. frame_start every 98 cycles.
- CLK_DIV=3 -> pixel_en pulses at cycles 2,5,8,…. hpos changes only at the edge after each pulse. line_start is 1 clk wide.
- SYNC_DELAY=2 -> hsync/display_on waveforms identical to the SYNC_DELAY=0 run but shifted by exactly 2 pixel_en ticks; hpos/vpos unchanged.
- B = H 4/1/1/1, V 2/1/1/1, pols 1. Set mode_sel=1 at vpos=3 -> active_mode flips at the next (0,0), H_TOTAL becomes 7, hsync is high only at hpos 5. A pulse on mode_sel lasting 3 cycles mid-frame and cleared before wrap -> no switch.
- FRAME_CNT_WIDTH=2, run 5 frames -> frame_cnt sequence 1,2,3,0,1.
- Assert rst_n low mid-line (hpos=6, vpos=2, mode B) -> outputs go to reset values within the same cycle without a clock edge. After release, the first pixel_en lands at cycle CLK_DIV-1, in set A.

Source files
------------

// File: rtl/vga_timing_dual.sv
// Dual timing-set VGA sync generator.
// Produces pixel coordinates, sync/blank levels, line/frame strobes and a
// frame counter for one of two compile-time timing sets, chosen at runtime.
// The set in use only changes at the wrap to pixel (0,0), so every frame is
// internally consistent. Sync and blank can lag the coordinates by a
// programmable number of pixel ticks to line up with a downstream pipeline.
module vga_timing_dual #(
    parameter int HPOS_WIDTH      = 11,
    parameter int VPOS_WIDTH      = 10,
    parameter int CLK_DIV         = 2,
    parameter int SYNC_DELAY      = 0,
    parameter int FRAME_CNT_WIDTH = 8,
    parameter int A_H_DISPLAY     = 640,
    parameter int A_H_FRONT       = 16,
    parameter int A_H_SYNC        = 96,
    parameter int A_H_BACK        = 48,
    parameter int A_V_DISPLAY     = 480,
    parameter int A_V_BOTTOM      = 10,
    parameter int A_V_SYNC        = 2,
    parameter int A_V_TOP         = 33,
    parameter bit A_HSYNC_POL     = 1'b0,
    parameter bit A_VSYNC_POL     = 1'b0,
    parameter int B_H_DISPLAY     = 800,
    parameter int B_H_FRONT       = 40,
    parameter int B_H_SYNC        = 128,
    parameter int B_H_BACK        = 88,
    parameter int B_V_DISPLAY     = 600,
    parameter int B_V_BOTTOM      = 1,
    parameter int B_V_SYNC        = 4,
    parameter int B_V_TOP         = 23,
    parameter bit B_HSYNC_POL     = 1'b1,
    parameter bit B_VSYNC_POL     = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mode_sel,
    output logic                       pixel_en,
    output logic [HPOS_WIDTH-1:0]      hpos,
    output logic [VPOS_WIDTH-1:0]      vpos,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       display_on,
    output logic                       line_start,
    output logic                       frame_start,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
    output logic                       active_mode
);

    localparam int A_H_TOTAL = A_H_DISPLAY + A_H_FRONT + A_H_SYNC + A_H_BACK;
    localparam int A_V_TOTAL = A_V_DISPLAY + A_V_BOTTOM + A_V_SYNC + A_V_TOP;
    localparam int B_H_TOTAL = B_H_DISPLAY + B_H_FRONT + B_H_SYNC + B_H_BACK;
    localparam int B_V_TOTAL = B_V_DISPLAY + B_V_BOTTOM + B_V_SYNC + B_V_TOP;

    localparam logic [HPOS_WIDTH-1:0] A_H_LAST = HPOS_WIDTH'(A_H_TOTAL - 1);
    localparam logic [HPOS_WIDTH-1:0] A_H_DISP = HPOS_WIDTH'(A_H_DISPLAY);
    localparam logic [HPOS_WIDTH-1:0] A_HS_BEG = HPOS_WIDTH'(A_H_DISPLAY + A_H_FRONT);
    localparam logic [HPOS_WIDTH-1:0] A_HS_END = HPOS_WIDTH'(A_H_DISPLAY + A_H_FRONT + A_H_SYNC);
    localparam logic [VPOS_WIDTH-1:0] A_V_LAST = VPOS_WIDTH'(A_V_TOTAL - 1);
    localparam logic [VPOS_WIDTH-1:0] A_V_DISP = VPOS_WIDTH'(A_V_DISPLAY);
    localparam logic [VPOS_WIDTH-1:0] A_VS_BEG = VPOS_WIDTH'(A_V_DISPLAY + A_V_BOTTOM);
    localparam logic [VPOS_WIDTH-1:0] A_VS_END = VPOS_WIDTH'(A_V_DISPLAY + A_V_BOTTOM + A_V_SYNC);

    localparam logic [HPOS_WIDTH-1:0] B_H_LAST = HPOS_WIDTH'(B_H_TOTAL - 1);
    localparam logic [HPOS_WIDTH-1:0] B_H_DISP = HPOS_WIDTH'(B_H_DISPLAY);
    localparam logic [HPOS_WIDTH-1:0] B_HS_BEG = HPOS_WIDTH'(B_H_DISPLAY + B_H_FRONT);
    localparam logic [HPOS_WIDTH-1:0] B_HS_END = HPOS_WIDTH'(B_H_DISPLAY + B_H_FRONT + B_H_SYNC);
    localparam logic [VPOS_WIDTH-1:0] B_V_LAST = VPOS_WIDTH'(B_V_TOTAL - 1);
    localparam logic [VPOS_WIDTH-1:0] B_V_DISP = VPOS_WIDTH'(B_V_DISPLAY);
    localparam logic [VPOS_WIDTH-1:0] B_VS_BEG = VPOS_WIDTH'(B_V_DISPLAY + B_V_BOTTOM);
    localparam logic [VPOS_WIDTH-1:0] B_VS_END = VPOS_WIDTH'(B_V_DISPLAY + B_V_BOTTOM + B_V_SYNC);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // {display_on, hsync, vsync} as seen after reset: blank, set-A syncs idle
    localparam logic [2:0] DLY_IDLE = {1'b0, ~A_HSYNC_POL, ~A_VSYNC_POL};

    logic [DIV_W-1:0]      div_cnt;
    logic [HPOS_WIDTH-1:0] h_next;
    logic [VPOS_WIDTH-1:0] v_next;
    logic                  mode_next;
    logic                  line_wrap;
    logic                  frame_wrap;
    logic [HPOS_WIDTH-1:0] h_last;
    logic [VPOS_WIDTH-1:0] v_last;
    logic [HPOS_WIDTH-1:0] h_disp, hs_beg, hs_end;
    logic [VPOS_WIDTH-1:0] v_disp, vs_beg, vs_end;
    logic                  hs_pol, vs_pol;
    logic                  hs_act, vs_act;
    logic [2:0]            dec;
    logic [2:0]            dly [0:SYNC_DELAY];

    // Pixel clock divider; pixel_en is registered so it is clean of glitches
    // and stays low during reset even when CLK_DIV is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            pixel_en <= 1'b0;
        end else begin
            pixel_en <= (div_cnt == DIV_LAST);
            div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    // Next raster position and mode; totals come from the set in use now.
    always_comb begin
        h_last     = active_mode ? B_H_LAST : A_H_LAST;
        v_last     = active_mode ? B_V_LAST : A_V_LAST;
        h_next     = hpos;
        v_next     = vpos;
        mode_next  = active_mode;
        line_wrap  = 1'b0;
        frame_wrap = 1'b0;
        if (pixel_en) begin
            if (hpos == h_last) begin
                h_next    = '0;
                line_wrap = 1'b1;
                if (vpos == v_last) begin
                    v_next     = '0;
                    frame_wrap = 1'b1;
                    mode_next  = mode_sel;
                end else begin
                    v_next = vpos + 1'b1;
                end
            end else begin
                h_next = hpos + 1'b1;
            end
        end
    end

    // Decode the next position against the set that will own it, so pixel
    // (0,0) of a new frame already uses the newly selected thresholds.
    always_comb begin
        h_disp = mode_next ? B_H_DISP : A_H_DISP;
        hs_beg = mode_next ? B_HS_BEG : A_HS_BEG;
        hs_end = mode_next ? B_HS_END : A_HS_END;
        v_disp = mode_next ? B_V_DISP : A_V_DISP;
        vs_beg = mode_next ? B_VS_BEG : A_VS_BEG;
        vs_end = mode_next ? B_VS_END : A_VS_END;
        hs_pol = mode_next ? B_HSYNC_POL : A_HSYNC_POL;
        vs_pol = mode_next ? B_VSYNC_POL : A_VSYNC_POL;
        hs_act = (h_next >= hs_beg) && (h_next < hs_end);
        vs_act = (v_next >= vs_beg) && (v_next < vs_end);
        dec    = {(h_next < h_disp) && (v_next < v_disp),
                  hs_act ? hs_pol : ~hs_pol,
                  vs_act ? vs_pol : ~vs_pol};
    end

    // Raster counters, strobes, frame counter and active set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos        <= '0;
            vpos        <= '0;
            active_mode <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            hpos        <= h_next;
            vpos        <= v_next;
            active_mode <= mode_next;
            line_start  <= line_wrap;
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Sync/blank delay line advanced once per pixel; stage 0 is the level
    // for the current pixel, stage SYNC_DELAY is what leaves the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= SYNC_DELAY; i++) begin
                dly[i] <= DLY_IDLE;
            end
        end else if (pixel_en) begin
            dly[0] <= dec;
            for (int i = 1; i <= SYNC_DELAY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign display_on = dly[SYNC_DELAY][2];
    assign hsync      = dly[SYNC_DELAY][1];
    assign vsync      = dly[SYNC_DELAY][0];

endmodule
